// File: rtl/lector_destinos_pkg.sv
// Shared definitions for the destination-FIFO reader.
//   - state encoding for the RESET/INIT/ACTIVE sequencer
//   - default data/counter widths
//   - destination ids (D0 = 0, D1 = 1)
package lector_destinos_pkg;

   localparam int BW_DEF    = 6;
   localparam int CNT_W_DEF = 5;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_e;

   localparam logic DEST_D0 = 1'b0;
   localparam logic DEST_D1 = 1'b1;

endpackage

// File: rtl/lector_destinos_arbitro_rr2.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk, reset_L   clock / async active-low reset
//   clr            synchronous pointer clear (pointer returns to 1)
//   en             grant enable; no grant while low
//   req[1:0]       request vector (bit n = destination n non-empty)
//   gnt[1:0]       one-hot grant, combinational from pointer and inputs
module arbitro_rr2 (
   input  logic       clk,
   input  logic       reset_L,
   input  logic       clr,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // last_q = id of the requester granted most recently; resets to 1 so
   // requester 0 wins the first tie.
   logic last_q;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         last_q <= 1'b1;
      end else if (clr) begin
         last_q <= 1'b1;
      end else if (|gnt) begin
         last_q <= gnt[1];
      end
   end

endmodule

// File: rtl/lector_destinos.sv
// Egress reader for destination FIFOs D0/D1.
// Pops non-empty FIFOs round-robin while enabled, registers each popped
// word tagged with its source, keeps saturating per-destination counts and
// answers count requests.
//
// state  | meaning
// -------+--------------------------------------------------------------
// RESET  | reset_L low; everything cleared
// INIT   | init seen high; counters/pointer held clear, no pops
// ACTIVE | normal operation; pops allowed when enable high and init low
//
// Ports:
//   clk, reset_L                 clock / async active-low reset
//   init                         sync clear of counters and pointer, blocks pops
//   enable                       permits pops
//   D0_empty, D1_empty           FIFO empty flags
//   D0_data_out, D1_data_out     FIFO read data (valid cycle after pop)
//   D0_rd, D1_rd                 pop strobes
//   data_out, dest_out, valid_out  registered popped word stream
//   req, idx                     count request / selector
//   data_cnt, valid_cnt          count response (one cycle after req)
//   idle_out                     both empty, nothing pending, ACTIVE
module lector_destinos
   import lector_destinos_pkg::*;
#(
   parameter int BW    = BW_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             init,
   input  logic             enable,
   input  logic             D0_empty,
   input  logic             D1_empty,
   input  logic [BW-1:0]    D0_data_out,
   input  logic [BW-1:0]    D1_data_out,
   output logic             D0_rd,
   output logic             D1_rd,
   output logic [BW-1:0]    data_out,
   output logic             dest_out,
   output logic             valid_out,
   input  logic             req,
   input  logic             idx,
   output logic [CNT_W-1:0] data_cnt,
   output logic             valid_cnt,
   output logic             idle_out
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q;
   logic             pend_q;
   logic             pend_dest_q;
   logic [BW-1:0]    data_out_q;
   logic             dest_out_q;
   logic             valid_out_q;
   logic [CNT_W-1:0] cnt_d0_q;
   logic [CNT_W-1:0] cnt_d1_q;
   logic [CNT_W-1:0] data_cnt_q;
   logic             valid_cnt_q;

   logic [1:0]       gnt;
   logic             pop_en;
   logic             cnt_clr;
   logic [BW-1:0]    cap_word;

   // init blocks new pops in the same cycle it rises.
   assign pop_en  = (state_q == ST_ACTIVE) & enable & ~init;
   assign cnt_clr = init | (state_q == ST_INIT);

   arbitro_rr2 u_arb (
      .clk     (clk),
      .reset_L (reset_L),
      .clr     (init),
      .en      (pop_en),
      .req     ({~D1_empty, ~D0_empty}),
      .gnt     (gnt)
   );

   assign D0_rd = gnt[0];
   assign D1_rd = gnt[1];

   assign cap_word = (pend_dest_q == DEST_D1) ? D1_data_out : D0_data_out;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= ST_RESET;
         pend_q      <= 1'b0;
         pend_dest_q <= DEST_D0;
         data_out_q  <= '0;
         dest_out_q  <= DEST_D0;
         valid_out_q <= 1'b0;
         cnt_d0_q    <= '0;
         cnt_d1_q    <= '0;
         data_cnt_q  <= '0;
         valid_cnt_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_RESET:  state_q <= init ? ST_INIT : ST_ACTIVE;
            ST_INIT:   if (!init) state_q <= ST_ACTIVE;
            ST_ACTIVE: if (init)  state_q <= ST_INIT;
            default:   state_q <= ST_RESET;
         endcase

         pend_q      <= |gnt;
         pend_dest_q <= gnt[1];

         // A pop already issued completes capture even if enable/init drop.
         valid_out_q <= pend_q;
         if (pend_q) begin
            data_out_q <= cap_word;
            dest_out_q <= pend_dest_q;
         end

         if (cnt_clr) begin
            cnt_d0_q <= '0;
            cnt_d1_q <= '0;
         end else if (pend_q) begin
            if (pend_dest_q == DEST_D0 && cnt_d0_q != CNT_MAX) cnt_d0_q <= cnt_d0_q + 1'b1;
            if (pend_dest_q == DEST_D1 && cnt_d1_q != CNT_MAX) cnt_d1_q <= cnt_d1_q + 1'b1;
         end

         // Samples the pre-increment value when a capture lands on the same edge.
         valid_cnt_q <= req;
         if (req) data_cnt_q <= idx ? cnt_d1_q : cnt_d0_q;
      end
   end

   assign data_out  = data_out_q;
   assign dest_out  = dest_out_q;
   assign valid_out = valid_out_q;
   assign data_cnt  = data_cnt_q;
   assign valid_cnt = valid_cnt_q;
   assign idle_out  = D0_empty & D1_empty & ~pend_q & (state_q == ST_ACTIVE);

endmodule
